// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_pkg: shared constants, scan state and width helper for the 7-segment scan controller
package seg7_pkg;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [7:0] AN_OFF = 8'hFF;
  typedef enum logic {BLANK, DRIVE} scan_state_e;
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: load/value/lz_en request side and multiplexed display drive side
interface seg7_scan_ctrl_if #(parameter int NUM_DIGITS = 4);
  logic load;
  logic [4*NUM_DIGITS-1:0] value;
  logic lz_en;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0] seg;
  logic frame_start;
  modport master(output load, value, lz_en, input an, seg, frame_start);
  modport slave(input load, value, lz_en, output an, seg, frame_start);
endinterface

// File: rtl/seg7_scan_ctrl_segment7.sv
// segment7: BCD digit to active-low segments {a,b,c,d,e,f,g}, non-BCD codes dark
module segment7 (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (digit_i)
      4'd0:    seg_o = 7'b0000001;
      4'd1:    seg_o = 7'b1001111;
      4'd2:    seg_o = 7'b0010010;
      4'd3:    seg_o = 7'b0000110;
      4'd4:    seg_o = 7'b1001100;
      4'd5:    seg_o = 7'b0100100;
      4'd6:    seg_o = 7'b0100000;
      4'd7:    seg_o = 7'b0001111;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0000100;
      default: seg_o = 7'b1111111;
    endcase
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: frame-stable multiplexed scan of a BCD word with anti-ghost blanking and leading-zero suppression
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input logic clk,
  input logic rst,
  seg7_scan_ctrl_if.slave bus
);
  localparam int CW = cnt_w(REFRESH_DIV);
  localparam int IW = cnt_w(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  scan_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] disp_q, disp_d, pend_q, pend_d;
  logic pend_v_q, pend_v_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0] seg_q, seg_d, dec_seg;
  logic fs_q, fs_d;
  logic wrap, boundary, lead_zero;
  logic [3:0] nib;
  assign nib = 4'(disp_q >> {idx_q, 2'b00});
  segment7 u_dec (.digit_i(nib), .seg_o(dec_seg));
  always_comb begin
    wrap      = cnt_q == CW'(REFRESH_DIV - 1);
    boundary  = wrap && idx_q == IW'(NUM_DIGITS - 1);
    cnt_d     = wrap ? '0 : cnt_q + CW'(1);
    idx_d     = !wrap ? idx_q : boundary ? '0 : idx_q + IW'(1);
    state_d   = (cnt_d < CW'(BLANK_CYCLES)) ? BLANK : DRIVE;
    disp_d    = (bus.load && boundary) ? bus.value : (boundary && pend_v_q) ? pend_q : disp_q;
    pend_d    = (bus.load && !boundary) ? bus.value : pend_q;
    pend_v_d  = bus.load ? !boundary : boundary ? 1'b0 : pend_v_q;
    lead_zero = bus.lz_en && idx_q != '0 && (disp_q >> {idx_q, 2'b00}) == '0;
    an_d      = (state_q == BLANK) ? AN_OFF[NUM_DIGITS-1:0] : ~(NUM_DIGITS'(1) << idx_q);
    seg_d     = (state_q == BLANK || lead_zero) ? SEG_OFF : dec_seg;
    fs_d      = cnt_q == '0 && idx_q == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= (BLANK_CYCLES > 0) ? BLANK : DRIVE;
      cnt_q    <= '0;
      idx_q    <= '0;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      an_q     <= AN_OFF[NUM_DIGITS-1:0];
      seg_q    <= SEG_OFF;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      fs_q     <= fs_d;
    end
  end
  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.frame_start = fs_q;
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for the board's common-anode 7-segment display bank. Takes a packed BCD word from the result/status logic, holds it in a frame-stable display register, and cycles one digit at a time through the existing `segment7` decoder. It drives the shared segment bus and active-low anode selects, with anti-ghost blanking and optional leading-zero suppression.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned, 2..8.
- `REFRESH_DIV`, 50000: clock cycles per digit slot, at least `BLANK_CYCLES`+1.
- `BLANK_CYCLES`, 500: cycles at the start of each slot during which all anodes are off.
- `clk`, in, 1: single clock for the block.
- `rst`, in, 1: synchronous reset, active-high.
- `load`, in, 1: one-cycle strobe that captures `value`.
- `value`, in, 4*`NUM_DIGITS`: BCD nibbles, where `value[3:0]` is digit 0 (rightmost).
- `lz_en`, in, 1: enables leading-zero suppression.
- `an`, out, `NUM_DIGITS`: anode selects, active-low one-hot or all ones.
- `seg`, out, 7: segment bus, active-low, in the `segment7` encoding.
- `frame_start`, out, 1: one-cycle pulse when digit 0's slot begins.

## Operation
- Registers:
  - `cnt`: 0..`REFRESH_DIV`-1.
  - `idx`: 0..`NUM_DIGITS`-1.
  - `disp`: the displayed word.
  - `pend` and `pend_v`: the pending word and its valid flag.
- State machine has two states, BLANK and DRIVE.
  - BLANK while `cnt` < `BLANK_CYCLES`, otherwise DRIVE.
  - When `cnt` = `REFRESH_DIV`-1, `cnt` wraps to 0, `idx` advances, and the state returns to BLANK.
  - `idx` wraps from `NUM_DIGITS`-1 to 0.
- Frame boundary is the cycle with `cnt` = `REFRESH_DIV`-1 and `idx` = `NUM_DIGITS`-1.
  - On that cycle, if `pend_v` is set: `disp` <= `pend` and `pend_v` <= 0.
- Load rules:
  - `load` in any other cycle: `pend` <= `value`, `pend_v` <= 1. A later load before the boundary overwrites the earlier one (last wins).
  - `load` on the frame-boundary cycle: `disp` <= `value` directly and `pend_v` <= 0. Any older `pend` is discarded.
- Output while in BLANK: `an` is all ones and `seg` = 7'b1111111.
- Output while in DRIVE:
  - `an` is all ones except bit `idx` = 0.
  - `seg` = `segment7`(`disp` nibble `idx`).
  - Nibbles 10..15 decode to all-off.
- Leading-zero suppression applies when `lz_en`=1, `idx`>0, and nibbles `idx`..`NUM_DIGITS`-1 of `disp` are all zero.
  - The anode is still driven; `seg` = 7'b1111111.
  - Digit 0 is never suppressed.
- `frame_start` pulses on the cycle the block enters BLANK with `idx`=0.

## Timing
- `an`, `seg` and `frame_start` are registered. At cycle t they reflect `cnt`, `idx` and `disp` as they stood at cycle t-1.
- Reset values:
  - Counters and data: `cnt`=0, `idx`=0, `disp`=0, `pend`=0, `pend_v`=0.
  - Outputs: `an` all ones, `seg`=7'b1111111, `frame_start`=0.
- First `frame_start` occurs in the first cycle after `rst` deasserts.
- Load-to-display latency:
  - Load before a boundary: visible at the next digit-0 DRIVE after that boundary, plus one output register cycle.
  - Worst case about `NUM_DIGITS`·`REFRESH_DIV`+`BLANK_CYCLES`+1 cycles.
- `rst` asserted mid-slot or mid-frame:
  - Next cycle all registers return to reset values.
  - A pending load is lost.
  - Display is dark until `BLANK_CYCLES` after release.
- Under no condition is more than one anode low in the same cycle.
- Anode changes always pass through all-ones for at least `BLANK_CYCLES` cycles.

## Structure
- Package `seg7_pkg` holds:
  - Localparams `SEG_OFF`=7'b1111111 and `AN_OFF`.
  - Scan state enum {BLANK, DRIVE}.
  - Function computing `$clog2` widths for `cnt` and `idx`.
- One sub-module: instance `u_dec` of existing `segment7`.
  - Input is the nibble selected from `disp` by `idx`.
  - Its output is registered into `seg` with the blanking and suppression overrides.

## Test plan
Benches run with `NUM_DIGITS`=4, `REFRESH_DIV`=8, `BLANK_CYCLES`=2.
- **Reset:** hold `rst` 3 cycles mid-scan. Expect `an`=4'b1111, `seg`=7'b1111111, `frame_start`=0 during reset, then `frame_start`=1 in the first cycle after release.
- **Scan order:** load 16'h4321 with `lz_en`=0, then run 2 frames.
  - Each slot: 2 cycles with `an`=1111, then 6 cycles of `an`=1110/1101/1011/0111 in turn.
  - `seg` in those slots = 1001111, 0010010, 0000110, 1001100.
  - Period is 32 cycles between `frame_start` pulses.
- **Frame-stable update:** with 16'h1111 displayed, load 16'h2222 while `idx`=1. Digits 2 and 3 still show 1; from the next frame all digits show 0010010.
- **Simultaneous boundary load, last-wins:** load 16'h5555 while `idx`=2, then 16'h6666 on the frame-boundary cycle. Next frame shows 6 on all digits; 5 never appears.
- **Leading zeros:** load 16'h0070 with `lz_en`=1.
  - Digits 3 and 2 have anodes driven with `seg`=1111111.
  - Digit 1 shows 0001111; digit 0 shows 0000001.
  - With `lz_en`=0, digits 3 and 2 show 0000001.
- **Invalid nibble and anode safety:** load 16'hF0A9.
  - Digits with nibbles A and F show 1111111; digit 0 shows 0000100.
  - Assertion across the whole run: `an` is all ones or has exactly one zero bit, every cycle.
